// File: rtl/act_ctrl_pkg.sv
// Shared constants for the activation buffer controller: FSM state codes,
// state_parallel encodings and default lane geometry.
package act_ctrl_pkg;

  localparam int DEF_IF_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ADDR_WIDTH   = 4;
  localparam int DEF_KERNEL_WIDTH = 3;
  localparam int DEF_LANE_BITS    = DEF_DATA_WIDTH * DEF_IF_WIDTH;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LD_FLAG  = 3'd1;
  localparam state_t ST_LD_DATA  = 3'd2;
  localparam state_t ST_RD_ISSUE = 3'd3;
  localparam state_t ST_RD_WAIT  = 3'd4;
  localparam state_t ST_FIN      = 3'd5;

  localparam logic [1:0] SP_IDLE  = 2'b00;
  localparam logic [1:0] SP_ISSUE = 2'b01;
  localparam logic [1:0] SP_WAIT  = 2'b10;

endpackage

// File: rtl/kernel_row_counter.sv
// Modulo-KERNEL_WIDTH row counter; last marks the final row of a kernel window.
module kernel_row_counter #(
  parameter int KERNEL_WIDTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int CW = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;

  logic [CW-1:0] count;

  assign last = (count == CW'(KERNEL_WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= last ? '0 : count + CW'(1);
  end

endmodule

// File: rtl/act_buffer_ctrl.sv
// Activation buffer sequencer: loads flag/data beats per row, then steps the
// buffer row by row, waiting on the PE array's row_cal_done for each row.
module act_buffer_ctrl
  import act_ctrl_pkg::*;
#(
  parameter int IF_WIDTH     = DEF_IF_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           cfg_mode,
  input  logic [ADDR_WIDTH:0]            cfg_num_rows,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [DATA_WIDTH*IF_WIDTH-1:0] ld_data,
  output logic                           mode,
  output logic                           wr_req_act_flag,
  output logic [IF_WIDTH-1:0]            wr_data_act_flag,
  output logic                           wr_req_act,
  output logic [DATA_WIDTH*IF_WIDTH-1:0] wr_data_act,
  output logic [1:0]                     state_parallel,
  output logic                           row_index_count_3,
  input  logic                           row_cal_done,
  output logic                           busy,
  output logic                           done
);

  localparam int                ROW_W    = ADDR_WIDTH + 1;
  localparam logic [ROW_W-1:0] MAX_ROWS = ROW_W'(2 ** ADDR_WIDTH);

  state_t           state, next_state;
  logic [ROW_W-1:0] rows_q, wr_row, rd_row;
  logic [ROW_W-1:0] rows_clamped;
  logic             start_ok, flag_hs, data_hs, cal_hs, k_last;

  assign rows_clamped = (cfg_num_rows > MAX_ROWS) ? MAX_ROWS : cfg_num_rows;
  assign start_ok     = (state == ST_IDLE) && start;
  assign flag_hs      = (state == ST_LD_FLAG) && ld_valid;
  assign data_hs      = (state == ST_LD_DATA) && ld_valid;
  assign cal_hs       = (state == ST_RD_WAIT) && row_cal_done;

  // Write strobes pass straight through on the accepting cycle; data is zeroed otherwise.
  assign wr_req_act_flag  = flag_hs;
  assign wr_data_act_flag = flag_hs ? ld_data[IF_WIDTH-1:0] : '0;
  assign wr_req_act       = data_hs;
  assign wr_data_act      = data_hs ? ld_data : '0;

  kernel_row_counter #(
    .KERNEL_WIDTH (KERNEL_WIDTH)
  ) u_kcnt (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .en    (state == ST_RD_ISSUE),
    .last  (k_last)
  );

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (start) next_state = (rows_clamped == '0) ? ST_FIN : ST_LD_FLAG;
      ST_LD_FLAG:  if (ld_valid) next_state = ST_LD_DATA;
      ST_LD_DATA:  if (ld_valid) next_state = (wr_row == rows_q - ROW_W'(1)) ? ST_RD_ISSUE
                                                                              : ST_LD_FLAG;
      ST_RD_ISSUE: next_state = ST_RD_WAIT;
      ST_RD_WAIT:  if (row_cal_done) next_state = (rd_row == rows_q - ROW_W'(1)) ? ST_FIN
                                                                                  : ST_RD_ISSUE;
      ST_FIN:      next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // NOTE: asynchronous reset clears every register at once, so a mid-tile reset lands in IDLE immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode   <= 1'b0;
      rows_q <= '0;
      wr_row <= '0;
      rd_row <= '0;
    end else begin
      state <= next_state;
      if (start_ok) begin
        mode   <= cfg_mode;
        rows_q <= rows_clamped;
        wr_row <= '0;
        rd_row <= '0;
      end else begin
        if (data_hs) wr_row <= wr_row + ROW_W'(1);
        if (cal_hs)  rd_row <= rd_row + ROW_W'(1);
      end
    end
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_ready          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      state_parallel    <= SP_IDLE;
      row_index_count_3 <= 1'b0;
    end else begin
      ld_ready          <= (next_state == ST_LD_FLAG) || (next_state == ST_LD_DATA);
      busy              <= (next_state != ST_IDLE);
      done              <= (next_state == ST_FIN);
      row_index_count_3 <= (next_state == ST_RD_ISSUE) && k_last;
      case (next_state)
        ST_RD_ISSUE: state_parallel <= SP_ISSUE;
        ST_RD_WAIT:  state_parallel <= SP_WAIT;
        default:     state_parallel <= SP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_buffer_ctrl.sv
// Self-checking bench for act_buffer_ctrl: a tile-level behavioural model is
// compared against every output each cycle, plus literal per-tile tallies.
module tb_act_buffer_ctrl;
  import act_ctrl_pkg::*;

  localparam int IFW = 16;
  localparam int NB  = 8 * IFW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            cfg_mode = 1'b0;
  logic [4:0]      cfg_num_rows = '0;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic [NB-1:0]   ld_data = '0;
  logic            mode;
  logic            wr_req_act_flag;
  logic [IFW-1:0]  wr_data_act_flag;
  logic            wr_req_act;
  logic [NB-1:0]   wr_data_act;
  logic [1:0]      state_parallel;
  logic            row_index_count_3;
  logic            row_cal_done = 1'b0;
  logic            busy;
  logic            done;

  act_buffer_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cfg_mode          (cfg_mode),
    .cfg_num_rows      (cfg_num_rows),
    .ld_valid          (ld_valid),
    .ld_ready          (ld_ready),
    .ld_data           (ld_data),
    .mode              (mode),
    .wr_req_act_flag   (wr_req_act_flag),
    .wr_data_act_flag  (wr_data_act_flag),
    .wr_req_act        (wr_req_act),
    .wr_data_act       (wr_data_act),
    .state_parallel    (state_parallel),
    .row_index_count_3 (row_index_count_3),
    .row_cal_done      (row_cal_done),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tile-level model: a tile is 2*rows accepted beats (flag, data alternating),
  // then rows issue/wait pairs, then one finish cycle.
  bit m_active, m_fin, m_issue, m_mode;
  int m_rows, m_beats, m_done_rows;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 0; m_fin <= 0; m_issue <= 0; m_mode <= 0;
      m_rows <= 0; m_beats <= 0; m_done_rows <= 0;
    end else if (m_fin) begin
      m_fin <= 0;
    end else if (!m_active) begin
      if (start) begin
        int r;
        r = (int'(cfg_num_rows) > 16) ? 16 : int'(cfg_num_rows);
        m_mode <= cfg_mode; m_rows <= r; m_beats <= 0; m_done_rows <= 0; m_issue <= 0;
        if (r == 0) m_fin <= 1;
        else        m_active <= 1;
      end
    end else if (m_beats < 2 * m_rows) begin
      if (ld_valid) begin
        m_beats <= m_beats + 1;
        if (m_beats + 1 == 2 * m_rows) m_issue <= 1;
      end
    end else if (m_issue) begin
      m_issue <= 0;
    end else if (row_cal_done) begin
      m_done_rows <= m_done_rows + 1;
      if (m_done_rows + 1 == m_rows) begin m_active <= 0; m_fin <= 1; end
      else m_issue <= 1;
    end
  end

  // Background stimulus: 0 = always high, 1 = toggle, 2 = random
  int vmode = 2, rmode = 2;
  always @(negedge clk) begin
    ld_data = {$urandom, $urandom, $urandom, $urandom};
    case (vmode)
      0:       ld_valid = 1'b1;
      1:       ld_valid = ~ld_valid;
      default: ld_valid = ($urandom_range(0, 9) < 7);
    endcase
    row_cal_done = (rmode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
  end

  // Tallies observed from the DUT, cleared per directed tile
  int cyc, n_flag, n_data, n_issue, n_done, done_at;
  logic [31:0] ric_mask;

  task automatic clr_tally();
    cyc = 0; n_flag = 0; n_data = 0; n_issue = 0; n_done = 0; done_at = -1; ric_mask = '0;
  endtask

  // Single compare process: every output, every cycle
  always @(negedge clk) begin
    bit loading, rd, fw, dw;
    #2;
    loading = m_active && (m_beats < 2 * m_rows);
    rd      = m_active && !loading;
    fw      = loading && (m_beats % 2 == 0) && ld_valid;
    dw      = loading && (m_beats % 2 == 1) && ld_valid;
    check("ld_ready", NB'(ld_ready), NB'(loading));
    check("wr_req_act_flag", NB'(wr_req_act_flag), NB'(fw));
    check("wr_data_act_flag", NB'(wr_data_act_flag), fw ? NB'(ld_data[IFW-1:0]) : '0);
    check("wr_req_act", NB'(wr_req_act), NB'(dw));
    check("wr_data_act", wr_data_act, dw ? ld_data : '0);
    check("state_parallel", NB'(state_parallel),
          !rd ? NB'(SP_IDLE) : (m_issue ? NB'(SP_ISSUE) : NB'(SP_WAIT)));
    check("row_index_count_3", NB'(row_index_count_3),
          NB'(rd && m_issue && (m_done_rows % 3 == 2)));
    check("busy", NB'(busy), NB'(m_active || m_fin));
    check("done", NB'(done), NB'(m_fin));
    check("mode", NB'(mode), NB'(m_mode));
    if (state_parallel == SP_ISSUE) begin
      n_issue++;
      if (row_index_count_3 && n_issue < 32) ric_mask[n_issue] = 1'b1;
    end
    if (wr_req_act_flag) n_flag++;
    if (wr_req_act)      n_data++;
    if (done) begin n_done++; done_at = cyc; end
    cyc++;
  end

  // Cycle 0 is the cycle start is presented; the loop ends once the model is idle.
  task automatic run_tile(input int rows, input bit md, input int vm, input int rm, input int stray);
    int c;
    vmode = vm; rmode = rm;
    @(negedge clk);
    clr_tally();
    start = 1'b1; cfg_num_rows = 5'(rows); cfg_mode = md;
    @(negedge clk);
    cfg_num_rows = 5'($urandom); cfg_mode = 1'($urandom);
    c = 1;
    while (m_active || m_fin) begin
      if (c >= 400) break;
      start = (c == stray);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("tile_completes_in_budget", NB'(c < 400), NB'(1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #3;
    check("reset_busy", NB'(busy), '0);
    check("reset_done", NB'(done), '0);
    check("reset_state_parallel", NB'(state_parallel), '0);
    check("reset_ld_ready", NB'(ld_ready), '0);

    // 4 rows, valid always, row_cal_done held high; stray start during RD_WAIT (cycle 10)
    run_tile(4, 1'b1, 0, 0, 10);
    check("t1_flag_writes", NB'(n_flag), NB'(4));
    check("t1_data_writes", NB'(n_data), NB'(4));
    check("t1_issues", NB'(n_issue), NB'(4));
    check("t1_ric3_mask", NB'(ric_mask), NB'(32'h8));
    check("t1_done_cycle", NB'(done_at), NB'(17));
    check("t1_done_pulses", NB'(n_done), NB'(1));
    check("t1_mode_held", NB'(mode), NB'(1));

    // 16 rows: no counter wrap, ric3 on issues 3,6,9,12,15
    run_tile(16, 1'b0, 0, 0, 0);
    check("t2_flag_writes", NB'(n_flag), NB'(16));
    check("t2_issues", NB'(n_issue), NB'(16));
    check("t2_ric3_mask", NB'(ric_mask), NB'(32'h9248));
    check("t2_done_cycle", NB'(done_at), NB'(65));

    // Zero rows and an over-range request clamped to 16
    run_tile(0, 1'b1, 2, 2, 0);
    check("t3_zero_writes", NB'(n_flag + n_data), NB'(0));
    check("t3_zero_issues", NB'(n_issue), NB'(0));
    check("t3_zero_done_cycle", NB'(done_at), NB'(1));
    run_tile(20, 1'b0, 0, 0, 0);
    check("t3_clamp_flag_writes", NB'(n_flag), NB'(16));
    check("t3_clamp_issues", NB'(n_issue), NB'(16));
    check("t3_clamp_done_cycle", NB'(done_at), NB'(65));

    // Toggling ld_valid
    run_tile(3, 1'b1, 1, 0, 0);
    check("t4_flag_writes", NB'(n_flag), NB'(3));
    check("t4_data_writes", NB'(n_data), NB'(3));
    check("t4_issues", NB'(n_issue), NB'(3));

    // Async reset while loading the data beat of row 2, then a fresh tile
    vmode = 0; rmode = 0;
    @(negedge clk);
    clr_tally();
    start = 1'b1; cfg_num_rows = 5'd4; cfg_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    check("t6_pre_reset_data_write", NB'(wr_req_act), NB'(1));
    check("t6_pre_reset_flag_count", NB'(n_flag), NB'(3));
    reset = 1'b1;
    #1;
    check("t6_reset_busy", NB'(busy), '0);
    check("t6_reset_ld_ready", NB'(ld_ready), '0);
    check("t6_reset_wr_req_act", NB'(wr_req_act), '0);
    check("t6_reset_mode", NB'(mode), '0);
    @(negedge clk);
    #4 reset = 1'b0;
    run_tile(2, 1'b1, 0, 0, 0);
    check("t6_reload_flag_writes", NB'(n_flag), NB'(2));
    check("t6_reload_data_writes", NB'(n_data), NB'(2));
    check("t6_reload_done_cycle", NB'(done_at), NB'(9));

    // Randomized tiles with random stalls, row_cal_done and stray starts
    for (int t = 0; t < 30; t++) begin
      run_tile($urandom_range(0, 20), 1'($urandom), 2, 2, $urandom_range(2, 40));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
